// File: rtl/led_pkg.sv
// Shared definitions for the LED blinker: FSM state encoding.
package led_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter: adds a W-bit value and subtracts 1 per edge,
// clamping at 2^W-1 and pulsing overflow when the unclamped result exceeds it.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] add_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         overflow_o
);

  localparam logic [W:0] MAX = {1'b0, {W{1'b1}}};

  logic [W-1:0] count_q, count_d;
  logic         ovf_q, ovf_d;
  logic [W:0]   sum;

  // dec is only raised while count is non-zero, so the sum never goes negative
  always_comb begin
    sum     = {1'b0, count_q} + {1'b0, add_i} - {{W{1'b0}}, dec_i};
    ovf_d   = (sum > MAX);
    count_d = ovf_d ? MAX[W-1:0] : sum[W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/led_blinker.sv
// Turns single-cycle blink requests into back-to-back LED blinks with fixed
// on/off times; a level input forces the LED steady on.
//
// state | meaning
// IDLE  | no blink in progress, waiting for pending != 0
// ON    | LED lit, timer counts up to ON_TICKS-1
// OFF   | LED dark, timer counts up to OFF_TICKS-1
module led_blinker
  import led_pkg::*;
#(
  parameter int ON_TICKS  = 50000,
  parameter int OFF_TICKS = 50000,
  parameter int TIMER_W   = 19,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_i,
  input  logic [CNT_W-1:0] req_count_i,
  input  logic             hold_i,
  output logic             led_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] pending_o,
  output logic             overflow_o
);

  localparam logic [TIMER_W-1:0] ON_LAST  = TIMER_W'(ON_TICKS - 1);
  localparam logic [TIMER_W-1:0] OFF_LAST = TIMER_W'(OFF_TICKS - 1);

  logic [1:0]         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               led_q, led_d;
  logic               dec;
  logic [CNT_W-1:0]   add_val;
  logic [CNT_W-1:0]   pending;

  assign add_val = req_i ? req_count_i : '0;

  sat_counter #(
    .W (CNT_W)
  ) u_pending (
    .clk        (clk),
    .rst_n      (rst_n),
    .add_i      (add_val),
    .dec_i      (dec),
    .count_o    (pending),
    .overflow_o (overflow_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      led_q   <= led_d;
    end
  end

  // Blink decisions use the registered pending count, before this edge's add
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dec     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (pending != '0) begin
          state_d = ST_ON;
          dec     = 1'b1;
        end
      end
      ST_ON: begin
        if (timer_q == ON_LAST) begin
          state_d = ST_OFF;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_OFF: begin
        if (timer_q == OFF_LAST) begin
          timer_d = '0;
          if (pending != '0) begin
            state_d = ST_ON;
            dec     = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    led_d  = (state_d == ST_ON) | hold_i;
    busy_o = (state_q != ST_IDLE) | (pending != '0);
  end

  assign led_o     = led_q;
  assign pending_o = pending;

endmodule

// File: tb/tb_led_blinker.sv
// Directed bench for led_blinker with ON_TICKS=4, OFF_TICKS=3, CNT_W=3.
module tb_led_blinker;

  logic       clk;
  logic       rst_n;
  logic       req;
  logic [2:0] req_count;
  logic       hold;
  logic       led;
  logic       busy;
  logic [2:0] pending;
  logic       overflow;

  int n_tests;
  int n_fails;

  led_blinker #(
    .ON_TICKS  (4),
    .OFF_TICKS (3),
    .TIMER_W   (3),
    .CNT_W     (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .req_count_i (req_count),
    .hold_i      (hold),
    .led_o       (led),
    .busy_o      (busy),
    .pending_o   (pending),
    .overflow_o  (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [2:0] n);
    req       = 1'b1;
    req_count = n;
    tick();
    req       = 1'b0;
    req_count = 3'd0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_led"},  32'(led),      0);
    check({tag, "_busy"}, 32'(busy),     0);
    check({tag, "_pend"}, 32'(pending),  0);
    check({tag, "_ovf"},  32'(overflow), 0);
  endtask

  task automatic async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_tests   = 0;
    n_fails   = 0;
    rst_n     = 1'b0;
    req       = 1'b0;
    req_count = 3'd0;
    hold      = 1'b0;

    #2;
    check_idle("por");
    #10;
    rst_n = 1'b1;
    tick();
    repeat (2) tick();
    check_idle("post_por");

    // 1: reset in the middle of a blink
    do_req(3'd1);
    tick();
    check("mid_led_hi", 32'(led), 1);
    async_reset();
    repeat (3) begin
      tick();
      check_idle("after_rst");
    end

    // 2: single blink timing
    do_req(3'd1);
    check("s_pend_E",  32'(pending), 1);
    check("s_led_E",   32'(led),     0);
    check("s_busy_E",  32'(busy),    1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("s_led",  32'(led),  (k <= 4) ? 1 : 0);
      check("s_busy", 32'(busy), (k <= 7) ? 1 : 0);
      check("s_pend", 32'(pending), 0);
    end

    // 3: three queued blinks, 4 on / 3 off each
    do_req(3'd3);
    check("t_pend_E", 32'(pending), 3);
    for (int k = 1; k <= 22; k++) begin
      tick();
      check("t_led",  32'(led),  ((k <= 21) && (((k - 1) % 7) < 4)) ? 1 : 0);
      check("t_pend", 32'(pending), (k >= 15) ? 0 : ((k >= 8) ? 1 : 2));
      check("t_busy", 32'(busy), (k <= 21) ? 1 : 0);
    end

    // 4: saturation and overflow pulses
    do_req(3'd6);
    check("o_pend6", 32'(pending),  6);
    check("o_ovf0",  32'(overflow), 0);
    do_req(3'd3);
    check("o_pend7", 32'(pending),  7);
    check("o_ovf1",  32'(overflow), 1);
    tick();
    check("o_ovf_pulse", 32'(overflow), 0);
    check("o_pend7b",    32'(pending),  7);
    do_req(3'd1);
    check("o_full_pend", 32'(pending),  7);
    check("o_full_ovf",  32'(overflow), 1);
    tick();
    check("o_full_ovf_pulse", 32'(overflow), 0);
    async_reset();

    // 5: add and dec on the same edge
    do_req(3'd2);
    check("d_pend2", 32'(pending), 2);
    do_req(3'd1);
    check("d_pend_same", 32'(pending),  2);
    check("d_led",       32'(led),      1);
    check("d_ovf",       32'(overflow), 0);
    async_reset();

    // 6: hold while idle, then hold during a sequence
    hold = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("h_led",  32'(led),  1);
      check("h_busy", 32'(busy), 0);
    end
    hold = 1'b0;
    tick();
    check("h_led_off", 32'(led), 0);

    hold = 1'b1;
    do_req(3'd2);
    check("hs_pend_E", 32'(pending), 2);
    for (int k = 1; k <= 15; k++) begin
      tick();
      check("hs_led",  32'(led), 1);
      check("hs_pend", 32'(pending), (k < 8) ? 1 : 0);
      check("hs_busy", 32'(busy), (k < 15) ? 1 : 0);
    end
    hold = 1'b0;
    tick();
    check("hs_led_off", 32'(led),  0);
    check("hs_idle",    32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
